convolve_ctrl: RTL and testbench
================================

CONVOLVE_CTRL -- requirements
Module: convolve_ctrl

Interface
REQ-001 Parameter L, default 40, meaning subframe length (number of x, h and y samples); legal range 1..64.
REQ-002 Parameter AW, default 11, meaning scratch-memory address width.
REQ-003 clk  in  1  single clock; all state updates on its rising edge.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 start  in  1  one-cycle request to begin a convolution.
REQ-006 xAddr, hAddr, yAddr  in  AW each  base addresses of x[], h[] and y[]; sampled on accepted start.
REQ-007 done  out  1  one-cycle pulse when y[L-1] has been written.
REQ-008 busy  out  1  high from accepted start until done.
REQ-009 memReadAddr  out  AW  scratch read address.
REQ-010 memIn  in  32  scratch read data, valid one cycle after memReadAddr; low 16 bits are the sample.
REQ-011 memWriteAddr  out  AW  scratch write address.
REQ-012 memWriteEn  out  1  scratch write strobe.
REQ-013 memOut  out  32  scratch write data.
REQ-014 L_macOutA, L_macOutB  out  16 each  L_mac multiplicands; L_macOutC out 32 accumulator; L_macIn in 32 L_mac result.
REQ-015 L_shlOutVar1  out  32, L_shlNumShiftOut out 16, L_shlReady out 1; L_shlIn in 32, L_shlDone in 1  L_shl handshake.

Function
REQ-016 Computes, for n=0..L-1: s=0; for i=0..n: s=L_mac(s,x[i],h[n-i]); s=L_shl(s,3); y[n]=high half of s.
REQ-017 States: IDLE, INIT, RD_X, RD_H, MAC, SHL_GO, SHL_WAIT, WRITE, FIN.
REQ-018 IDLE: start=1 -> latch bases, n=0 -> INIT; otherwise stay in IDLE.
REQ-019 INIT: acc=0, i=0 -> RD_X.
REQ-020 RD_X: memReadAddr=xAddr+i -> RD_H.
REQ-021 RD_H: capture memIn[15:0] as xs; memReadAddr=hAddr+(n-i) -> MAC.
REQ-022 MAC: L_macOutA=xs, L_macOutB=memIn[15:0], L_macOutC=acc; acc<=L_macIn; i==n -> SHL_GO, else i<=i+1 -> RD_X.
REQ-023 Each term costs exactly 3 cycles; the per-n accumulation loop costs 3(n+1) cycles.
REQ-024 SHL_GO: L_shlOutVar1=acc, L_shlNumShiftOut=3, L_shlReady=1 for exactly one cycle -> SHL_WAIT.
REQ-025 SHL_WAIT: hold L_shlOutVar1 and L_shlNumShiftOut; on L_shlDone=1 capture L_shlIn -> WRITE; wait indefinitely otherwise.
REQ-026 WRITE: memWriteEn=1 for one cycle, memWriteAddr=yAddr+n, memOut=sign-extended L_shlIn[31:16]; n==L-1 -> FIN, else n<=n+1 -> INIT.
REQ-027 FIN: done=1 for one cycle, busy=0 next -> IDLE.
REQ-028 start while busy is ignored; bases are not re-latched.
REQ-029 Address arithmetic is modulo 2^AW (wrap-around, no error).
REQ-030 memWriteEn is 0 in every state except WRITE; L_shlReady is 0 in every state except SHL_GO.
REQ-031 Saturation is delegated to L_mac/L_shl; the block performs no saturation of its own.

Reset
REQ-032 reset=1 -> state IDLE; done, busy, memWriteEn and L_shlReady 0; all address, operand and data outputs 0; acc, i and n 0.
REQ-033 reset mid-operation aborts immediately; no further write occurs; a start in the first post-reset cycle is accepted.

Configuration
REQ-034 Macro CONVOLVE_CTRL_CYCCNT_EN defined: adds output cycleCount (16 bits), cleared on accepted start, incremented each busy cycle, saturating at 0xFFFF, held after done, cleared by reset.
REQ-035 Macro undefined: no cycleCount port and no counter logic; all other behaviour is identical.

Structure
REQ-036 Shared package convolve_pkg holds the state encoding, the shift constant 3, and the default L and AW.
REQ-037 No sub-module; L_mac and L_shl instances stay in the datapath (pipe) stage that this block drives.

Verification
REQ-038 L=4, x=[0x4000,0,0,0], h=[0x1000,0x2000,0x3000,0x4000] -> y=[0x4000,0x7FFF,0x7FFF,0x7FFF] (saturating), one done pulse.
REQ-039 L=4, x=h=all 0 -> four writes of 0 at yAddr..yAddr+3; exactly 10 MAC-state cycles.
REQ-040 yAddr=0x7FE, L=4 -> writes to 0x7FE, 0x7FF, 0x000, 0x001.
REQ-041 Second start pulsed 5 cycles after the first -> ignored; single done; y unchanged versus a single-start run.
REQ-042 reset asserted in SHL_WAIT for n=2 -> next cycle IDLE, all outputs 0, no write to yAddr+2.
REQ-043 L_shlDone held low for 20 cycles -> FSM stays in SHL_WAIT with L_shlOutVar1 stable; with CONVOLVE_CTRL_CYCCNT_EN, cycleCount grows by 20 relative to a run with immediate L_shlDone.

Source files
------------

// File: rtl/convolve_pkg.sv
// Shared definitions for the convolution controller: FSM encoding, the fixed
// post-accumulation shift and the default subframe geometry.
package convolve_pkg;

    typedef enum logic [3:0] {
        IDLE,
        INIT,
        RD_X,
        RD_H,
        MAC,
        SHL_GO,
        SHL_WAIT,
        WRITE,
        FIN
    } convState;

    localparam int SHIFT_AMT  = 3;
    localparam int DEFAULT_L  = 40;
    localparam int DEFAULT_AW = 11;

    // y[n] is the high half of the shifted accumulator, stored sign-extended
    function automatic logic [31:0] sextHigh(input logic [31:0] v);
        return {{16{v[31]}}, v[31:16]};
    endfunction

endpackage

// File: rtl/convolve_ctrl.sv
// Sequencer for y[n] = L_shl(sum x[i]*h[n-i], 3) over a shared scratch memory.
// Optional cycle counter output enabled by CONVOLVE_CTRL_CYCCNT_EN.
module convolve_ctrl
    import convolve_pkg::*;
#(
    parameter int L  = DEFAULT_L,
    parameter int AW = DEFAULT_AW
) (
    input  logic          clk,
    input  logic          reset,
`ifdef CONVOLVE_CTRL_CYCCNT_EN
    output logic [15:0]   cycleCount,
`endif
    input  logic          start,
    input  logic [AW-1:0] xAddr,
    input  logic [AW-1:0] hAddr,
    input  logic [AW-1:0] yAddr,
    output logic          done,
    output logic          busy,
    output logic [AW-1:0] memReadAddr,
    input  logic [31:0]   memIn,
    output logic [AW-1:0] memWriteAddr,
    output logic          memWriteEn,
    output logic [31:0]   memOut,
    output logic [15:0]   L_macOutA,
    output logic [15:0]   L_macOutB,
    output logic [31:0]   L_macOutC,
    input  logic [31:0]   L_macIn,
    output logic [31:0]   L_shlOutVar1,
    output logic [15:0]   L_shlNumShiftOut,
    output logic          L_shlReady,
    input  logic [31:0]   L_shlIn,
    input  logic          L_shlDone
);

    convState             state;
    logic [AW-1:0]        xBase;
    logic [AW-1:0]        hBase;
    logic [AW-1:0]        yBase;
    logic [6:0]           nIdx;
    logic [6:0]           iIdx;
    logic signed [31:0]   acc;
    logic signed [15:0]   xs;
    logic                 unusedBits;

    assign unusedBits = ^{memIn[31:16], L_shlIn[15:0]};

    // h[n-i] arrives on memIn during MAC, so it feeds L_mac straight through
    assign L_macOutA = xs;
    assign L_macOutB = (state == MAC) ? memIn[15:0] : 16'd0;
    assign L_macOutC = acc;

    always_ff @(posedge clk) begin
        if (reset) begin
            state            <= IDLE;
            xBase            <= '0;
            hBase            <= '0;
            yBase            <= '0;
            nIdx             <= '0;
            iIdx             <= '0;
            acc              <= '0;
            xs               <= '0;
            done             <= 1'b0;
            busy             <= 1'b0;
            memReadAddr      <= '0;
            memWriteAddr     <= '0;
            memWriteEn       <= 1'b0;
            memOut           <= '0;
            L_shlOutVar1     <= '0;
            L_shlNumShiftOut <= '0;
            L_shlReady       <= 1'b0;
        end else begin
            memWriteEn <= 1'b0;
            L_shlReady <= 1'b0;
            done       <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        xBase <= xAddr;
                        hBase <= hAddr;
                        yBase <= yAddr;
                        nIdx  <= '0;
                        busy  <= 1'b1;
                        state <= INIT;
                    end
                end
                INIT: begin
                    acc         <= '0;
                    iIdx        <= '0;
                    memReadAddr <= xBase;
                    state       <= RD_X;
                end
                RD_X: begin
                    memReadAddr <= hBase + AW'(nIdx - iIdx);
                    state       <= RD_H;
                end
                RD_H: begin
                    xs    <= memIn[15:0];
                    state <= MAC;
                end
                MAC: begin
                    acc <= L_macIn;
                    if (iIdx == nIdx) begin
                        L_shlOutVar1     <= L_macIn;
                        L_shlNumShiftOut <= 16'(SHIFT_AMT);
                        L_shlReady       <= 1'b1;
                        state            <= SHL_GO;
                    end else begin
                        iIdx        <= iIdx + 7'd1;
                        memReadAddr <= xBase + AW'(iIdx + 7'd1);
                        state       <= RD_X;
                    end
                end
                SHL_GO: begin
                    state <= SHL_WAIT;
                end
                SHL_WAIT: begin
                    if (L_shlDone) begin
                        memWriteEn   <= 1'b1;
                        memWriteAddr <= yBase + AW'(nIdx);
                        memOut       <= sextHigh(L_shlIn);
                        state        <= WRITE;
                    end
                end
                WRITE: begin
                    if (nIdx == 7'(L - 1)) begin
                        done  <= 1'b1;
                        state <= FIN;
                    end else begin
                        nIdx  <= nIdx + 7'd1;
                        state <= INIT;
                    end
                end
                FIN: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef CONVOLVE_CTRL_CYCCNT_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            cycleCount <= '0;
        end else if (state == IDLE && start) begin
            cycleCount <= '0;
        end else if (busy && cycleCount != 16'hFFFF) begin
            cycleCount <= cycleCount + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_convolve_ctrl.sv
// Scoreboard bench for convolve_ctrl: reference convolution with ITU-style
// saturating L_mac/L_shl, behavioural scratch memory and a delayed L_shl unit.
module tb_convolve_ctrl;

    localparam int L   = 4;
    localparam int AW  = 11;
    localparam int MSZ = 2048;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic [AW-1:0] xAddr, hAddr, yAddr;
    logic          done, busy;
    logic [AW-1:0] memReadAddr, memWriteAddr;
    logic [31:0]   memIn;
    logic          memWriteEn;
    logic [31:0]   memOut;
    logic [15:0]   L_macOutA, L_macOutB;
    logic [31:0]   L_macOutC, L_macIn;
    logic [31:0]   L_shlOutVar1;
    logic [15:0]   L_shlNumShiftOut;
    logic          L_shlReady;
    logic [31:0]   L_shlIn;
    logic          L_shlDone;
`ifdef CONVOLVE_CTRL_CYCCNT_EN
    logic [15:0]   cycleCount;
`endif

    always #5 clk = ~clk;

    convolve_ctrl #(.L(L), .AW(AW)) dut (
        .clk(clk),
        .reset(reset),
`ifdef CONVOLVE_CTRL_CYCCNT_EN
        .cycleCount(cycleCount),
`endif
        .start(start),
        .xAddr(xAddr),
        .hAddr(hAddr),
        .yAddr(yAddr),
        .done(done),
        .busy(busy),
        .memReadAddr(memReadAddr),
        .memIn(memIn),
        .memWriteAddr(memWriteAddr),
        .memWriteEn(memWriteEn),
        .memOut(memOut),
        .L_macOutA(L_macOutA),
        .L_macOutB(L_macOutB),
        .L_macOutC(L_macOutC),
        .L_macIn(L_macIn),
        .L_shlOutVar1(L_shlOutVar1),
        .L_shlNumShiftOut(L_shlNumShiftOut),
        .L_shlReady(L_shlReady),
        .L_shlIn(L_shlIn),
        .L_shlDone(L_shlDone)
    );

    int checks = 0;
    int failures = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, req);
        end
    endtask

    function automatic logic signed [31:0] sat32(input longint v);
        if (v > 64'sd2147483647) return 32'sh7fffffff;
        if (v < -64'sd2147483648) return 32'sh80000000;
        return 32'(v);
    endfunction

    function automatic logic signed [31:0] lmac(input logic signed [31:0] s,
                                                input logic signed [15:0] a,
                                                input logic signed [15:0] b);
        longint p;
        p = sat32(longint'(a) * longint'(b) * 2);
        return sat32(longint'(s) + p);
    endfunction

    function automatic logic signed [31:0] lshl(input logic signed [31:0] v, input int k);
        logic signed [31:0] r;
        r = v;
        for (int j = 0; j < k && j < 40; j++) r = sat32(longint'(r) * 2);
        return r;
    endfunction

    assign L_macIn = lmac(L_macOutC, L_macOutA, L_macOutB);

    // scratch memory: registered read, one-cycle latency
    logic [31:0] mem [MSZ];
    always @(posedge clk) begin
        memIn <= mem[memReadAddr];
        if (memWriteEn) mem[memWriteAddr] <= memOut;
    end

    typedef struct packed {
        logic [AW-1:0] a;
        logic [31:0]   d;
    } wrT;
    wrT expQ[$];
    int shlQ[$];

    int doneCnt = 0;
    int busyCyc = 0;
    int shlReqs = 0;

    always @(negedge clk) begin
        wrT e;
        if (memWriteEn) begin
            if (expQ.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpectedWrite actual=%0h required=none", memWriteAddr);
            end else begin
                e = expQ.pop_front();
                chk("wrAddr", 64'(memWriteAddr), 64'(e.a));
                chk("wrData", 64'(memOut), 64'(e.d));
            end
        end
        if (done) doneCnt++;
        if (busy) busyCyc++;
    end

    // L_shl unit: answers a configurable number of cycles after the request
    logic        shlPend = 1'b0;
    int          shlCnt = 0;
    logic [31:0] holdVar = '0;
    initial begin
        L_shlDone = 1'b0;
        L_shlIn   = '0;
    end
    always @(negedge clk) begin
        L_shlDone = 1'b0;
        if (reset) begin
            shlPend = 1'b0;
        end else if (shlPend) begin
            chk("shlVarStable", 64'(L_shlOutVar1), 64'(holdVar));
            if (shlCnt <= 1) begin
                L_shlDone = 1'b1;
                L_shlIn   = lshl(holdVar, int'(L_shlNumShiftOut));
                shlPend   = 1'b0;
            end else begin
                shlCnt--;
            end
        end else if (L_shlReady) begin
            shlPend = 1'b1;
            holdVar = L_shlOutVar1;
            shlCnt  = (shlQ.size() != 0) ? shlQ.pop_front() : 1;
            shlReqs++;
            chk("shlShiftAmt", 64'(L_shlNumShiftOut), 64'd3);
        end
    end

    logic signed [15:0] gx [L];
    logic signed [15:0] gh [L];
    logic [15:0]        gyFixed [L];
    int                 gDel [L];
    int                 expBusy;

    task automatic startRun(input logic [AW-1:0] xb, input logic [AW-1:0] hb,
                            input logic [AW-1:0] yb, input bit fixed);
        logic signed [31:0] s;
        logic [15:0]        y;
        logic [AW-1:0]      ad;
        wrT                 e;
        int                 sumDel;
        sumDel = 0;
        for (int k = 0; k < L; k++) begin
            ad = xb + AW'(k);
            mem[ad] = {16'($urandom), gx[k]};
            ad = hb + AW'(k);
            mem[ad] = {16'($urandom), gh[k]};
        end
        for (int n = 0; n < L; n++) begin
            s = 0;
            for (int i = 0; i <= n; i++) s = lmac(s, gx[i], gh[n - i]);
            s = lshl(s, 3);
            y = fixed ? gyFixed[n] : s[31:16];
            e.a = yb + AW'(n);
            e.d = {{16{y[15]}}, y};
            expQ.push_back(e);
            shlQ.push_back(gDel[n]);
            sumDel += gDel[n];
        end
        expBusy = 3 * L + 3 * L * (L + 1) / 2 + sumDel + 1;
        doneCnt = 0;
        busyCyc = 0;
        xAddr = xb;
        hAddr = hb;
        yAddr = yb;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic finishRun(input string tag);
        int cyc;
        cyc = 0;
        while (doneCnt == 0 && cyc < 3000) begin
            @(posedge clk);
            cyc++;
        end
        if (doneCnt == 0) begin
            checks++;
            failures++;
            $display("FAIL %s_timeout actual=nodone required=done", tag);
        end
        repeat (3) @(posedge clk);
        #1;
        chk({tag, "_doneCount"}, 64'(doneCnt), 64'd1);
        chk({tag, "_busyCycles"}, 64'(busyCyc), 64'(expBusy));
        chk({tag, "_pendingWrites"}, 64'(expQ.size()), 64'd0);
        chk({tag, "_busyLow"}, 64'(busy), 64'd0);
`ifdef CONVOLVE_CTRL_CYCCNT_EN
        chk({tag, "_cycleCount"}, 64'(cycleCount), 64'(expBusy));
`endif
    endtask

    task automatic chkIdleOutputs(input string tag);
        chk({tag, "_ctrl"}, 64'({done, busy, memWriteEn, L_shlReady}), 64'd0);
        chk({tag, "_addrs"}, 64'({memReadAddr, memWriteAddr}), 64'd0);
        chk({tag, "_memOut"}, 64'(memOut), 64'd0);
        chk({tag, "_macOps"}, 64'({L_macOutA, L_macOutB, L_macOutC}), 64'd0);
        chk({tag, "_shlOps"}, 64'({L_shlOutVar1, L_shlNumShiftOut}), 64'd0);
    endtask

    task automatic setDelays(input int d);
        for (int k = 0; k < L; k++) gDel[k] = d;
    endtask

    initial begin
        int baseBusy;
        int reqBase;
        int cyc;
        logic [AW-1:0] oldY;

        for (int k = 0; k < MSZ; k++) mem[k] = 32'hDEAD_0000 | 32'(k);
        reset = 1'b1;
        start = 1'b0;
        xAddr = '0;
        hAddr = '0;
        yAddr = '0;
        repeat (3) @(posedge clk);
        #1;
        chkIdleOutputs("reset");
`ifdef CONVOLVE_CTRL_CYCCNT_EN
        chk("reset_cycleCount", 64'(cycleCount), 64'd0);
`endif
        reset = 1'b0;
        @(posedge clk);
        #1;

        // saturating directed case
        gx = '{16'sh4000, 16'sh0000, 16'sh0000, 16'sh0000};
        gh = '{16'sh1000, 16'sh2000, 16'sh3000, 16'sh4000};
        gyFixed = '{16'h4000, 16'h7FFF, 16'h7FFF, 16'h7FFF};
        setDelays(1);
        startRun(11'h010, 11'h300, 11'h500, 1'b1);
        finishRun("sat");
        baseBusy = busyCyc;

        // all-zero operands
        gx = '{default: 16'sh0};
        gh = '{default: 16'sh0};
        setDelays(2);
        startRun(11'h020, 11'h320, 11'h520, 1'b0);
        finishRun("zero");

        // y region wraps past the top of the address space
        for (int k = 0; k < L; k++) begin
            gx[k] = 16'($urandom);
            gh[k] = 16'($urandom);
        end
        setDelays(1);
        startRun(11'h064, 11'h2BC, 11'h7FE, 1'b0);
        finishRun("wrap");

        // second start during busy must be ignored
        for (int k = 0; k < L; k++) begin
            gx[k] = 16'($urandom);
            gh[k] = 16'($urandom);
        end
        setDelays(1);
        startRun(11'h040, 11'h340, 11'h540, 1'b0);
        repeat (4) @(posedge clk);
        #1;
        xAddr = 11'h0A0;
        hAddr = 11'h0B0;
        yAddr = 11'h600;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        finishRun("dblStart");

        // slow L_shl answer on the first sample only
        gx = '{16'sh4000, 16'sh0000, 16'sh0000, 16'sh0000};
        gh = '{16'sh1000, 16'sh2000, 16'sh3000, 16'sh4000};
        gyFixed = '{16'h4000, 16'h7FFF, 16'h7FFF, 16'h7FFF};
        gDel = '{21, 1, 1, 1};
        startRun(11'h010, 11'h300, 11'h580, 1'b1);
        finishRun("slowShl");
        chk("slowShl_extraCycles", 64'(busyCyc - baseBusy), 64'd20);

        // reset while waiting on L_shl for n=2
        for (int k = 0; k < L; k++) begin
            gx[k] = 16'($urandom);
            gh[k] = 16'($urandom);
        end
        gDel = '{1, 1, 8, 1};
        oldY = 11'h5C0;
        mem[oldY + AW'(2)] = 32'hA5A5_5A5A;
        reqBase = shlReqs;
        startRun(11'h050, 11'h350, oldY, 1'b0);
        cyc = 0;
        while (shlReqs < reqBase + 3 && cyc < 500) begin
            @(posedge clk);
            cyc++;
        end
        chk("abort_reachedN2", 64'(shlReqs - reqBase), 64'd3);
        @(posedge clk);
        #1;
        reset = 1'b1;
        expQ.delete();
        shlQ.delete();
        @(posedge clk);
        #1;
        chkIdleOutputs("abort");
        reset = 1'b0;
        setDelays(1);
        startRun(11'h050, 11'h350, 11'h640, 1'b0);
        finishRun("postReset");
        chk("abort_noWriteN2", 64'(mem[oldY + AW'(2)]), 64'hA5A5_5A5A);

        // randomized runs
        for (int r = 0; r < 8; r++) begin
            for (int k = 0; k < L; k++) begin
                gx[k] = (r % 2 == 0) ? 16'($urandom) : 16'($urandom_range(0, 255));
                gh[k] = 16'($urandom);
                gDel[k] = $urandom_range(1, 5);
            end
            startRun(11'($urandom_range(0, 500)), 11'($urandom_range(600, 1100)),
                     11'($urandom_range(1200, 2047)), 1'b0);
            finishRun("rand");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
